// File: rtl/display_counter_pkg.sv
// Shared types and constants for the display tick counter.
package display_counter_pkg;

  // Behaviour of the value when a step hits the terminal count.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  // Prescaler divisors for a 100 MHz system clock.
  localparam int unsigned TICK_DIV_1S_100MHZ    = 100_000_000;
  localparam int unsigned TICK_DIV_100MS_100MHZ = 10_000_000;

  // Bits needed to hold 0..div-1, never less than one.
  function automatic int unsigned prescale_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// One shift per cycle; result lands BIN_W cycles after the start cycle.
// A start while busy restarts from the new input; bcd_o keeps the last
// complete result until a conversion finishes.
//
// state       | meaning
// ------------+------------------------------------------------
// CONV_IDLE   | no conversion running, bcd_o holds last result
// CONV_SHIFT  | add-3/shift iterations in progress
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    CONV_IDLE  = 1'b0,
    CONV_SHIFT = 1'b1
  } conv_state_e;

  conv_state_e       state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  acc_q, acc_d, acc_adj, acc_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              done_q, done_d;

  // Add 3 to every digit that is 5 or more before the next shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_next = {acc_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  end

  // Next-state: start wins over an in-flight conversion; last shift publishes.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    if (start_i) begin
      state_d = CONV_SHIFT;
      bin_d   = bin_i;
      acc_d   = '0;
      cnt_d   = CNT_W'(BIN_W);
    end else if (state_q == CONV_SHIFT) begin
      bin_d = {bin_q[BIN_W-2:0], 1'b0};
      acc_d = acc_next;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d = CONV_IDLE;
        bcd_d   = acc_next;
        done_d  = 1'b1;
      end
    end
  end

  // Converter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == CONV_SHIFT);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_tick_counter.sv
// Display value counter: a prescaler turns clk into step ticks, each step
// moves value up or down toward LIMIT with wrap or saturate behaviour.
// Optional macro BCD_DIGITS_EN adds a BCD view of value (bcd, bcd_valid)
// produced by a sequential converter restarted on every value change.
module display_tick_counter
  import display_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_1S_100MHZ,
  parameter int unsigned VALUE_W  = 16,
  parameter int unsigned LIMIT    = 2**VALUE_W - 1,
  parameter count_mode_e MODE     = MODE_WRAP,
  parameter int unsigned DIGITS   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               load,
  input  logic [VALUE_W-1:0] load_value,
  input  logic               count_down,
  output logic [VALUE_W-1:0] value,
  output logic               tick,
  output logic               rollover,
  output logic               at_limit
`ifdef BCD_DIGITS_EN
  , output logic [4*DIGITS-1:0] bcd
  , output logic                bcd_valid
`endif
);

  localparam int unsigned       PRE_W    = prescale_width(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [VALUE_W-1:0] LIMIT_V = VALUE_W'(LIMIT);

  if (TICK_DIV < 1 || VALUE_W < 2 || DIGITS < 1 || LIMIT > 2**VALUE_W - 1) begin : g_bad_params
    $error("display_tick_counter: illegal parameter set");
  end

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               tick_q, tick_d;
  logic               roll_q, roll_d;
  logic               step;
  logic [VALUE_W-1:0] load_clamped;

  assign load_clamped = (load_value > LIMIT_V) ? LIMIT_V : load_value;

  // Prescaler and value next-state; clear beats load, load beats a step.
  always_comb begin
    pre_d   = pre_q;
    value_d = value_q;
    tick_d  = 1'b0;
    roll_d  = 1'b0;
    step    = 1'b0;
    if (clear) begin
      pre_d   = '0;
      value_d = '0;
    end else if (load) begin
      pre_d   = '0;
      value_d = load_clamped;
    end else if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (step) begin
      tick_d = 1'b1;
      if (!count_down) begin
        if (value_q >= LIMIT_V) begin
          if (MODE == MODE_WRAP) begin
            value_d = '0;
            roll_d  = 1'b1;
          end
        end else begin
          value_d = value_q + 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          if (MODE == MODE_WRAP) begin
            value_d = LIMIT_V;
            roll_d  = 1'b1;
          end
        end else begin
          value_d = value_q - 1'b1;
        end
      end
    end
  end

  // Counter state; pulses are registered so they line up with the new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      value_q <= '0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      value_q <= value_d;
      tick_q  <= tick_d;
      roll_q  <= roll_d;
    end
  end

  assign value    = value_q;
  assign tick     = tick_q;
  assign rollover = roll_q;
  assign at_limit = ((value_q == LIMIT_V) && !count_down) ||
                    ((value_q == '0) && count_down);

`ifdef BCD_DIGITS_EN
  logic [VALUE_W-1:0]  value_seen_q;
  logic                bcd_start;
  logic                bcd_busy;
  logic                bcd_done;
  logic [4*DIGITS-1:0] bcd_result;
  logic                bcd_valid_q;

  // A difference from the last seen value kicks off a fresh conversion.
  assign bcd_start = (value_q != value_seen_q);

  // Remember the value the converter was last started on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_seen_q <= '0;
    end else begin
      value_seen_q <= value_q;
    end
  end

  bin_to_bcd_seq #(
    .BIN_W  (VALUE_W),
    .DIGITS (DIGITS)
  ) u_bin_to_bcd (
    .clk_i   (clk),
    .rst_ni  (reset),
    .start_i (bcd_start),
    .bin_i   (value_q),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd_result)
  );

  // Valid flag: cleared by any start, set once a conversion completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_valid_q <= 1'b0;
    end else if (bcd_start) begin
      bcd_valid_q <= 1'b0;
    end else if (bcd_done) begin
      bcd_valid_q <= 1'b1;
    end
  end

  // done is visible in the same cycle the result lands, so valid rises with bcd.
  assign bcd       = bcd_result;
  assign bcd_valid = (bcd_valid_q | bcd_done) & ~bcd_start & ~bcd_busy;
`endif

endmodule

// File: tb/tb_display_tick_counter.sv
// Bench for display_tick_counter: a wrap-mode and a saturate-mode instance
// share stimulus; expected steps are queued per scenario and popped on tick.
module tb_display_tick_counter;
  import display_counter_pkg::*;

  localparam int unsigned TD  = 4;
  localparam int unsigned VW  = 4;
  localparam int unsigned LIM = 9;
  localparam int unsigned DG  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic load = 1'b0;
  logic count_down = 1'b0;
  logic [VW-1:0] load_value = '0;

  logic [VW-1:0] w_value, s_value;
  logic w_tick, s_tick, w_roll, s_roll, w_lim, s_lim;
`ifdef BCD_DIGITS_EN
  logic [4*DG-1:0] w_bcd, s_bcd;
  logic w_bcd_valid, s_bcd_valid;
`endif

  always #5 clk = ~clk;

  display_tick_counter #(
    .TICK_DIV(TD), .VALUE_W(VW), .LIMIT(LIM), .MODE(MODE_WRAP), .DIGITS(DG)
  ) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .count_down(count_down), .value(w_value),
    .tick(w_tick), .rollover(w_roll), .at_limit(w_lim)
`ifdef BCD_DIGITS_EN
    , .bcd(w_bcd), .bcd_valid(w_bcd_valid)
`endif
  );

  display_tick_counter #(
    .TICK_DIV(TD), .VALUE_W(VW), .LIMIT(LIM), .MODE(MODE_SAT), .DIGITS(DG)
  ) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .count_down(count_down), .value(s_value),
    .tick(s_tick), .rollover(s_roll), .at_limit(s_lim)
`ifdef BCD_DIGITS_EN
    , .bcd(s_bcd), .bcd_valid(s_bcd_valid)
`endif
  );

  typedef struct {
    int         cyc;
    logic [3:0] wv;
    logic       wr;
    logic [3:0] sv;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] ew, es;
  logic       et, er;
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic lim_of(input logic [3:0] v);
    return ((v == 4'd9) && !count_down) || ((v == 4'd0) && count_down);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (w_value !== 4'd0 || s_value !== 4'd0) begin
      n_err++;
      $display("FAIL reset_value got %0d/%0d want 0/0", w_value, s_value);
    end
    n_cmp++;
    if ({w_tick, s_tick, w_roll, s_roll, w_lim, s_lim} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags got t=%b/%b r=%b/%b l=%b/%b want all 0",
               w_tick, s_tick, w_roll, s_roll, w_lim, s_lim);
    end
    ew = 4'd0;
    es = 4'd0;
  endtask

  task automatic test_wrap_up();
    for (int k = 1; k <= 10; k++)
      sb.push_back('{cyc: 4*k, wv: 4'(k % 10), wr: (k == 10), sv: (k > 9) ? 4'd9 : 4'(k)});
    reset = 1'b1;
    enable = 1'b1;
    count_down = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      et = 1'b0; er = 1'b0;
      if (sb.size() != 0) begin
        if (sb[0].cyc == c) begin
          et = 1'b1; er = sb[0].wr; ew = sb[0].wv; es = sb[0].sv;
          void'(sb.pop_front());
        end
      end
      n_cmp++;
      if ({w_tick, s_tick, w_roll, s_roll} !== {et, et, er, 1'b0}) begin
        n_err++;
        $display("FAIL wrap_up_pulses c=%0d got t=%b/%b r=%b/%b want t=%b r=%b/0",
                 c, w_tick, s_tick, w_roll, s_roll, et, er);
      end
      n_cmp++;
      if (w_value !== ew || s_value !== es) begin
        n_err++;
        $display("FAIL wrap_up_value c=%0d got %0d/%0d want %0d/%0d", c, w_value, s_value, ew, es);
      end
      n_cmp++;
      if (w_lim !== lim_of(ew) || s_lim !== lim_of(es)) begin
        n_err++;
        $display("FAIL wrap_up_at_limit c=%0d got %b/%b want %b/%b", c, w_lim, s_lim, lim_of(ew), lim_of(es));
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL wrap_up_missing_steps got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_sat_down();
    load = 1'b1; load_value = 4'd2; count_down = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    n_cmp++;
    if (w_value !== 4'd2 || s_value !== 4'd2 || w_tick !== 1'b0 || s_tick !== 1'b0) begin
      n_err++;
      $display("FAIL sat_down_load got %0d/%0d tick %b/%b want 2/2 tick 0/0", w_value, s_value, w_tick, s_tick);
    end
    ew = 4'd2; es = 4'd2;
    sb.push_back('{cyc: 4,  wv: 4'd1, wr: 1'b0, sv: 4'd1});
    sb.push_back('{cyc: 8,  wv: 4'd0, wr: 1'b0, sv: 4'd0});
    sb.push_back('{cyc: 12, wv: 4'd9, wr: 1'b1, sv: 4'd0});
    sb.push_back('{cyc: 16, wv: 4'd8, wr: 1'b0, sv: 4'd0});
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      et = 1'b0; er = 1'b0;
      if (sb.size() != 0) begin
        if (sb[0].cyc == c) begin
          et = 1'b1; er = sb[0].wr; ew = sb[0].wv; es = sb[0].sv;
          void'(sb.pop_front());
        end
      end
      n_cmp++;
      if ({w_tick, s_tick, w_roll, s_roll} !== {et, et, er, 1'b0}) begin
        n_err++;
        $display("FAIL sat_down_pulses c=%0d got t=%b/%b r=%b/%b want t=%b r=%b/0",
                 c, w_tick, s_tick, w_roll, s_roll, et, er);
      end
      n_cmp++;
      if (w_value !== ew || s_value !== es) begin
        n_err++;
        $display("FAIL sat_down_value c=%0d got %0d/%0d want %0d/%0d", c, w_value, s_value, ew, es);
      end
      n_cmp++;
      if (w_lim !== lim_of(ew) || s_lim !== lim_of(es)) begin
        n_err++;
        $display("FAIL sat_down_at_limit c=%0d got %b/%b want %b/%b", c, w_lim, s_lim, lim_of(ew), lim_of(es));
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sat_down_missing_steps got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_enable_hold();
    sb.push_back('{cyc: 7, wv: 4'd7, wr: 1'b0, sv: 4'd0});
    for (int c = 1; c <= 7; c++) begin
      if (c == 3) enable = 1'b0;
      if (c == 6) enable = 1'b1;
      @(posedge clk);
      #1;
      et = 1'b0; er = 1'b0;
      if (sb.size() != 0) begin
        if (sb[0].cyc == c) begin
          et = 1'b1; er = sb[0].wr; ew = sb[0].wv; es = sb[0].sv;
          void'(sb.pop_front());
        end
      end
      n_cmp++;
      if ({w_tick, s_tick, w_roll, s_roll} !== {et, et, er, 1'b0}) begin
        n_err++;
        $display("FAIL enable_hold_pulses c=%0d got t=%b/%b r=%b/%b want t=%b r=%b/0",
                 c, w_tick, s_tick, w_roll, s_roll, et, er);
      end
      n_cmp++;
      if (w_value !== ew || s_value !== es) begin
        n_err++;
        $display("FAIL enable_hold_value c=%0d got %0d/%0d want %0d/%0d", c, w_value, s_value, ew, es);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL enable_hold_missing_step got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_load_clear();
    repeat (3) @(posedge clk);
    #1;
    load = 1'b1; clear = 1'b1; load_value = 4'd7;
    @(posedge clk);
    #1;
    load = 1'b0; clear = 1'b0;
    n_cmp++;
    if ({w_value, s_value} !== 8'h00 || {w_tick, s_tick, w_roll, s_roll} !== 4'b0) begin
      n_err++;
      $display("FAIL clear_over_load got %0d/%0d t=%b/%b r=%b/%b want 0/0 no pulses",
               w_value, s_value, w_tick, s_tick, w_roll, s_roll);
    end
    repeat (3) @(posedge clk);
    #1;
    load = 1'b1; load_value = 4'd7; count_down = 1'b0;
    @(posedge clk);
    #1;
    load = 1'b0;
    n_cmp++;
    if (w_value !== 4'd7 || s_value !== 4'd7 || {w_tick, s_tick} !== 2'b00) begin
      n_err++;
      $display("FAIL load_at_terminal got %0d/%0d t=%b/%b want 7/7 t=0/0", w_value, s_value, w_tick, s_tick);
    end
    ew = 4'd7; es = 4'd7;
    sb.push_back('{cyc: 4, wv: 4'd8, wr: 1'b0, sv: 4'd8});
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      et = 1'b0; er = 1'b0;
      if (sb.size() != 0) begin
        if (sb[0].cyc == c) begin
          et = 1'b1; er = sb[0].wr; ew = sb[0].wv; es = sb[0].sv;
          void'(sb.pop_front());
        end
      end
      n_cmp++;
      if ({w_tick, s_tick, w_roll, s_roll} !== {et, et, er, 1'b0} || w_value !== ew || s_value !== es) begin
        n_err++;
        $display("FAIL after_load_step c=%0d got %0d/%0d t=%b/%b r=%b/%b want %0d/%0d t=%b r=%b/0",
                 c, w_value, s_value, w_tick, s_tick, w_roll, s_roll, ew, es, et, er);
      end
    end
    load = 1'b1; load_value = 4'd15;
    @(posedge clk);
    #1;
    load = 1'b0;
    n_cmp++;
    if (w_value !== 4'd9 || s_value !== 4'd9 || {w_lim, s_lim} !== 2'b11 || {w_tick, s_tick} !== 2'b00) begin
      n_err++;
      $display("FAIL load_clamp got %0d/%0d lim=%b/%b t=%b/%b want 9/9 lim=1/1 t=0/0",
               w_value, s_value, w_lim, s_lim, w_tick, s_tick);
    end
    ew = 4'd9; es = 4'd9;
    sb.push_back('{cyc: 4, wv: 4'd0, wr: 1'b1, sv: 4'd9});
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      et = 1'b0; er = 1'b0;
      if (sb.size() != 0) begin
        if (sb[0].cyc == c) begin
          et = 1'b1; er = sb[0].wr; ew = sb[0].wv; es = sb[0].sv;
          void'(sb.pop_front());
        end
      end
      n_cmp++;
      if ({w_tick, s_tick, w_roll, s_roll} !== {et, et, er, 1'b0} || w_value !== ew || s_value !== es) begin
        n_err++;
        $display("FAIL limit_step c=%0d got %0d/%0d t=%b/%b r=%b/%b want %0d/%0d t=%b r=%b/0",
                 c, w_value, s_value, w_tick, s_tick, w_roll, s_roll, ew, es, et, er);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL load_clear_missing_steps got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_direction();
    sb.push_back('{cyc: 4, wv: 4'd9, wr: 1'b1, sv: 4'd8});
    sb.push_back('{cyc: 8, wv: 4'd8, wr: 1'b0, sv: 4'd7});
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) count_down = 1'b1;
      @(posedge clk);
      #1;
      et = 1'b0; er = 1'b0;
      if (sb.size() != 0) begin
        if (sb[0].cyc == c) begin
          et = 1'b1; er = sb[0].wr; ew = sb[0].wv; es = sb[0].sv;
          void'(sb.pop_front());
        end
      end
      n_cmp++;
      if ({w_tick, s_tick, w_roll, s_roll} !== {et, et, er, 1'b0} || w_value !== ew || s_value !== es) begin
        n_err++;
        $display("FAIL direction c=%0d got %0d/%0d t=%b/%b r=%b/%b want %0d/%0d t=%b r=%b/0",
                 c, w_value, s_value, w_tick, s_tick, w_roll, s_roll, ew, es, et, er);
      end
      n_cmp++;
      if (w_lim !== lim_of(ew) || s_lim !== lim_of(es)) begin
        n_err++;
        $display("FAIL direction_at_limit c=%0d got %b/%b want %b/%b", c, w_lim, s_lim, lim_of(ew), lim_of(es));
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL direction_missing_steps got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset();
    count_down = 1'b0;
    load = 1'b1; load_value = 4'd5;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (w_value !== 4'd5 || s_value !== 4'd5) begin
      n_err++;
      $display("FAIL async_reset_setup got %0d/%0d want 5/5", w_value, s_value);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({w_value, s_value} !== 8'h00 || {w_tick, s_tick, w_roll, s_roll, w_lim, s_lim} !== 6'b0) begin
      n_err++;
      $display("FAIL async_reset_immediate got %0d/%0d t=%b/%b r=%b/%b l=%b/%b want 0 everywhere",
               w_value, s_value, w_tick, s_tick, w_roll, s_roll, w_lim, s_lim);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    ew = 4'd0; es = 4'd0;
    sb.push_back('{cyc: 4, wv: 4'd1, wr: 1'b0, sv: 4'd1});
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      et = 1'b0; er = 1'b0;
      if (sb.size() != 0) begin
        if (sb[0].cyc == c) begin
          et = 1'b1; er = sb[0].wr; ew = sb[0].wv; es = sb[0].sv;
          void'(sb.pop_front());
        end
      end
      n_cmp++;
      if ({w_tick, s_tick, w_roll, s_roll} !== {et, et, er, 1'b0} || w_value !== ew || s_value !== es) begin
        n_err++;
        $display("FAIL after_reset c=%0d got %0d/%0d t=%b/%b r=%b/%b want %0d/%0d t=%b r=%b/0",
                 c, w_value, s_value, w_tick, s_tick, w_roll, s_roll, ew, es, et, er);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL after_reset_missing_step got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

`ifdef BCD_DIGITS_EN
  task automatic test_bcd();
    int seen;
    seen = 0;
    enable = 1'b0;
    load = 1'b1; load_value = 4'd9;
    @(posedge clk);
    #1;
    load = 1'b0;
    n_cmp++;
    if (w_bcd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bcd_valid_drop got %b want 0", w_bcd_valid);
    end
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (seen == 0 && w_bcd_valid === 1'b1) seen = c;
    end
    n_cmp++;
    if (seen != VW + 1 || w_bcd !== 8'h09) begin
      n_err++;
      $display("FAIL bcd_result got valid at %0d bcd=%h want %0d and 09", seen, w_bcd, VW + 1);
    end
    enable = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_enable_hold();
    test_load_clear();
    test_direction();
    test_async_reset();
`ifdef BCD_DIGITS_EN
    test_bcd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_tick_counter.md
Name: display_tick_counter

Overview:
- Parametrised display-value counter. A prescaler divides the system clock into step ticks; each tick moves a VALUE_W-bit value up or down toward a programmable limit.
- Adds over the previous fixed counter: enable, clear, load, direction control, wrap/saturate mode, limit flag and rollover pulse.
- Sits between the clock domain and the seven-segment/score display logic; the value feeds the display driver directly.

Parameters:
- TICK_DIV, 100000000, clock cycles per step (>=1); step period is exactly TICK_DIV cycles.
- VALUE_W, 16, width of value.
- LIMIT, 2**VALUE_W-1, terminal count in up mode; wrap target in down mode (must be <= 2**VALUE_W-1).
- MODE, MODE_WRAP, MODE_WRAP or MODE_SAT (behaviour at terminal count).
- DIGITS, 5, BCD digit count; used only with BCD_DIGITS_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous and active-low.
- enable  in  1  prescaler runs while high; holds while low.
- clear  in  1  synchronous: value and prescaler to 0.
- load  in  1  synchronous: value <= load_value, prescaler to 0.
- load_value  in  VALUE_W  load data; values above LIMIT clamp to LIMIT.
- count_down  in  1  0 = increment, 1 = decrement; sampled on each step.
- value  out  VALUE_W  current count, registered.
- tick  out  1  one-cycle pulse, coincident with each value step.
- rollover  out  1  one-cycle pulse when a wrap occurs.
- at_limit  out  1  combinational: (value==LIMIT && !count_down) || (value==0 && count_down).

Behaviour:
- Reset (reset low, async): value=0, prescaler=0, tick=0, rollover=0; bcd=0 and bcd_valid=0 if the feature is built.
- Per-edge priority: clear > load > step. Clear or load suppresses the step, tick and rollover in that cycle.
- Prescaler: counts 0..TICK_DIV-1 while enable=1. At TICK_DIV-1 it returns to 0 and a step occurs on the same edge.
- tick and rollover are registered and high for the one cycle after the stepping edge, aligned with the new value.
- TICK_DIV=1: step on every enabled cycle.
- enable low: prescaler holds its phase; no steps. clear/load still act.
- Up step: value<LIMIT gives value+1. At LIMIT:
  - MODE_WRAP: value goes to 0, rollover pulses.
  - MODE_SAT: value holds, tick still pulses, no rollover.
- Down step: value>0 gives value-1. At 0:
  - MODE_WRAP: value goes to LIMIT, rollover pulses.
  - MODE_SAT: value holds.
- Direction change takes effect on the next step; the prescaler phase is not disturbed.
- Arithmetic is unsigned VALUE_W-bit. No carry beyond LIMIT is ever visible.
- Reset mid-count: all state cleared immediately. Counting resumes with a full TICK_DIV period after reset deasserts.

Optional Feature:
- Macro: BCD_DIGITS_EN.
- Defined:
  - Adds outputs bcd [4*DIGITS-1:0] (digit 0 in LSBs) and bcd_valid.
  - A sequential double-dabble converter starts on every value change and finishes VALUE_W+1 cycles later.
  - bcd updates atomically on completion. A value change mid-conversion restarts the conversion; bcd holds the last complete result.
  - bcd_valid is low from the start of any conversion until the next completion.
  - Requires TICK_DIV >= VALUE_W+2 for every value to be displayed.
- Undefined: ports and converter are absent; no extra logic.

Decomposition:
- Package display_counter_pkg:
  - enum count_mode_e {MODE_WRAP, MODE_SAT}.
  - Localparam helper for prescaler width ($clog2 of TICK_DIV, minimum 1).
  - Default TICK_DIV constants for 100 MHz (1 s, 100 ms).
- One sub-module: bin_to_bcd_seq (start, bin, busy, done, bcd), instantiated only under BCD_DIGITS_EN.

Test Plan (TICK_DIV=4, VALUE_W=4, LIMIT=9 unless noted):
- Release reset, enable=1, up, MODE_WRAP → value 0,1,..,9,0 at cycles 4,8,..,40; rollover pulses once, in the same cycle value returns to 0; at_limit high while value=9.
- MODE_SAT, count_down=1, load_value=2 → value 2,1,0,0; tick keeps pulsing every 4 cycles; rollover never pulses.
- Drop enable for 3 cycles after prescaler=2, then re-enable → the next step arrives exactly 2 cycles after re-enable.
- Assert load(7) and clear in the same cycle as a terminal prescaler count → value=0, no tick; with load alone, value=7, no tick, next step 4 cycles later. load_value=15 → value=9.
- Pull reset low asynchronously mid-period while value=5 → value and outputs are 0 before the next clk edge; the first step comes 4 cycles after release.
- BCD_DIGITS_EN, VALUE_W=16, TICK_DIV=20, load 12345 → bcd_valid drops, then after 17 cycles bcd=0x12345 and bcd_valid=1.
